// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM state type and sizing constants for the serial add/sub block
package addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int N_NIB_DEF = 4;
    localparam int NIB_W     = 4;
endpackage

// File: rtl/nibble_addsub.sv
// nibble_addsub: 4-bit add/subtract slice; mode inverts b, caller supplies cin (mode on first nibble)
//   a, b : nibble operands    mode : 0 add, 1 subtract    cin : carry in
//   s    : nibble sum         cout : nibble carry out
import addsub_pkg::*;
module nibble_addsub (
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             mode,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b ^ {NIB_W{mode}}} + {{NIB_W{1'b0}}, cin};
endmodule

// File: rtl/serial_addsub16.sv
// serial_addsub16: nibble-serial W-bit adder/subtractor, one nibble per cycle, valid/ready handshakes
//   in_valid/in_ready, a, b, mode : operand handshake (sampled only in IDLE)
//   out_valid/out_ready           : result handshake, outputs held in DONE
//   result, cout, ovf, zero       : sum/difference, final carry, signed overflow, zero flag
import addsub_pkg::*;
module serial_addsub16 #(
    parameter int N_NIB = N_NIB_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*N_NIB-1:0] a,
    input  logic [4*N_NIB-1:0] b,
    input  logic               mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*N_NIB-1:0] result,
    output logic               cout,
    output logic               ovf,
    output logic               zero
);
    localparam int W  = NIB_W * N_NIB;
    localparam int IW = (N_NIB > 1) ? $clog2(N_NIB) : 1;

    state_t          r_state, w_next;
    logic [W-1:0]    r_a, r_b, r_result, w_res_next;
    logic            r_mode, r_carry, r_cout, r_ovf, r_zero;
    logic [IW-1:0]   r_idx;
    logic [NIB_W-1:0] w_s;
    logic            w_c, w_last;

    nibble_addsub u_nib (
        .a    (r_a[r_idx*NIB_W +: NIB_W]),
        .b    (r_b[r_idx*NIB_W +: NIB_W]),
        .mode (r_mode),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    assign w_last = (r_idx == IW'(N_NIB - 1));

    // Full result including the nibble being written this cycle, so flags can be
    // registered on the same edge as the last nibble.
    always_comb begin
        w_res_next = r_result;
        w_res_next[r_idx*NIB_W +: NIB_W] = w_s;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            r_carry <= mode;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_result <= w_res_next;
            r_carry  <= w_c;
            r_idx    <= w_last ? '0 : r_idx + IW'(1);
            if (w_last) begin
                r_cout <= w_c;
                r_ovf  <= ~(r_a[W-1] ^ r_b[W-1] ^ r_mode) & (w_res_next[W-1] ^ r_a[W-1]);
                r_zero <= (w_res_next == '0);
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
endmodule

// File: tb/tb_serial_addsub16.sv
// tb_serial_addsub16: table-driven directed check of serial_addsub16 plus hold and reset sequences
module tb_serial_addsub16;
    logic        clk = 0, rst_n = 0, in_valid = 0, mode = 0, out_ready = 0;
    logic [15:0] a = 0, b = 0, result;
    logic        in_ready, out_valid, cout, ovf, zero;
    int          checks = 0, failures = 0;

    typedef struct {
        logic [15:0] a, b;
        logic        mode;
        logic [15:0] res;
        logic        c, o, z;
    } vec_t;

    vec_t vecs[9];

    serial_addsub16 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v, input int n);
        int lat;
        @(negedge clk);
        chk($sformatf("v%0d in_ready", n), 32'(in_ready), 1);
        in_valid = 1; a = v.a; b = v.b; mode = v.mode;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; a = 16'hDEAD; b = 16'hBEEF; mode = ~v.mode;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk($sformatf("v%0d latency", n), lat, 4);
        chk($sformatf("v%0d result", n), 32'(result), 32'(v.res));
        chk($sformatf("v%0d cout", n), 32'(cout), 32'(v.c));
        chk($sformatf("v%0d ovf", n), 32'(ovf), 32'(v.o));
        chk($sformatf("v%0d zero", n), 32'(zero), 32'(v.z));
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 0;
        chk($sformatf("v%0d post in_ready", n), 32'(in_ready), 1);
        chk($sformatf("v%0d post out_valid", n), 32'(out_valid), 0);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'hABCD, 16'h1111, 1'b1, 16'h9ABC, 1'b1, 1'b0, 1'b0};

        #2;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset result", 32'(result), 0);
        chk("reset flags", {29'b0, cout, ovf, zero}, 0);
        chk("reset in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1;

        foreach (vecs[i]) do_op(vecs[i], i);

        // hold in DONE with out_ready low while offering new operands
        @(negedge clk);
        in_valid = 1; a = 16'h1111; b = 16'h2222; mode = 0;
        @(posedge clk);
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; mode = 1;
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold%0d out_valid", k), 32'(out_valid), 1);
            chk($sformatf("hold%0d in_ready", k), 32'(in_ready), 0);
            chk($sformatf("hold%0d result", k), 32'(result), 32'h3333);
            chk($sformatf("hold%0d flags", k), {29'b0, cout, ovf, zero}, 0);
            @(negedge clk);
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 0;
        chk("hold post in_ready", 32'(in_ready), 1);
        do_op('{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0}, 100);

        // asynchronous reset mid-operation, after two nibbles are written
        @(negedge clk);
        in_valid = 1; a = 16'h1234; b = 16'h4321; mode = 0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre-reset partial result", 32'(result), 32'h0055);
        rst_n = 0;
        #1;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst result", 32'(result), 0);
        chk("rst flags", {29'b0, cout, ovf, zero}, 0);
        chk("rst in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1;
        begin
            int seen = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("no stale out_valid", seen, 0);
        end
        chk("after rst in_ready", 32'(in_ready), 1);
        do_op(vecs[8], 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
